// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage constants: default widths, NOP encoding and IF FSM state encoding.
package inst_fetch_pkg;

  localparam int unsigned LEN_INST_DEF = 32;
  localparam int unsigned LEN_ADDR_DEF = 32;

  localparam logic [LEN_INST_DEF-1:0] NOP_INST = '0;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_skid_buf.sv
// One-entry skid buffer parking a fetched instruction while IF/ID is stalled.
module inst_skid_buf #(
  parameter int unsigned LEN_INST = 32,
  parameter int unsigned LEN_ADDR = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic                i_unload,
  input  logic                i_clear,
  input  logic [LEN_INST-1:0] i_inst,
  input  logic [LEN_ADDR-1:0] i_pc4,
  output logic                o_valid,
  output logic [LEN_INST-1:0] o_inst,
  output logic [LEN_ADDR-1:0] o_pc4
);

  logic                r_valid;
  logic [LEN_INST-1:0] r_inst;
  logic [LEN_ADDR-1:0] r_pc4;

  // Emptying wins over loading; the two never coincide in the fetch FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc4   <= '0;
    end else if (i_clear || i_unload) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc4   <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, imem request handshake, IF/ID register, stall skid and redirect flush.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned         LEN_INST = LEN_INST_DEF,
  parameter int unsigned         LEN_ADDR = LEN_ADDR_DEF,
  parameter logic [LEN_ADDR-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [LEN_ADDR-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [LEN_INST-1:0] imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [LEN_ADDR-1:0] redirect_pc,
  output logic                if_valid,
  output logic [LEN_INST-1:0] if_inst,
  output logic [LEN_ADDR-1:0] if_pc4
);

  if_state_e           r_state;
  if_state_e           w_state_n;
  logic [LEN_ADDR-1:0] r_pc;
  logic [LEN_ADDR-1:0] w_pc_n;
  logic [LEN_ADDR-1:0] r_addr;
  logic [LEN_ADDR-1:0] w_addr_n;
  logic                r_req;
  logic                w_req_n;
  logic                r_if_valid;
  logic                w_if_valid_n;
  logic [LEN_INST-1:0] r_if_inst;
  logic [LEN_INST-1:0] w_if_inst_n;
  logic [LEN_ADDR-1:0] r_if_pc4;
  logic [LEN_ADDR-1:0] w_if_pc4_n;
  logic                w_ack;
  logic                w_bubble;
  logic [LEN_ADDR-1:0] w_pc_plus4;
  logic [LEN_ADDR-1:0] w_redir_pc;
  logic                w_skid_load;
  logic                w_skid_unload;
  logic                w_skid_clear;
  logic                w_skid_valid;
  logic [LEN_INST-1:0] w_skid_inst;
  logic [LEN_ADDR-1:0] w_skid_pc4;

  // An ack only counts against a request actually on the bus.
  assign w_ack      = imem_ack & r_req;
  assign w_pc_plus4 = r_pc + LEN_ADDR'(4);
  assign w_redir_pc = redirect_pc & ~LEN_ADDR'(3);

  inst_skid_buf #(
    .LEN_INST (LEN_INST),
    .LEN_ADDR (LEN_ADDR)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_inst   (imem_rdata),
    .i_pc4    (w_pc_plus4),
    .o_valid  (w_skid_valid),
    .o_inst   (w_skid_inst),
    .o_pc4    (w_skid_pc4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IF_FETCH;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_inst  <= '0;
      r_if_pc4   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_pc       <= w_pc_n;
      r_addr     <= w_addr_n;
      r_req      <= w_req_n;
      r_if_valid <= w_if_valid_n;
      r_if_inst  <= w_if_inst_n;
      r_if_pc4   <= w_if_pc4_n;
    end
  end

  // Redirect outranks ack and stall in every state.
  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_if_valid_n  = r_if_valid;
    w_if_inst_n   = r_if_inst;
    w_if_pc4_n    = r_if_pc4;
    w_bubble      = 1'b0;
    w_skid_load   = 1'b0;
    w_skid_unload = 1'b0;
    w_skid_clear  = 1'b0;
    case (r_state)
      IF_FETCH: begin
        if (redirect) begin
          w_pc_n       = w_redir_pc;
          w_bubble     = 1'b1;
          w_skid_clear = 1'b1;
          w_state_n    = w_ack ? IF_FETCH : IF_DROP;
        end else if (w_ack && !stall) begin
          w_if_valid_n = 1'b1;
          w_if_inst_n  = imem_rdata;
          w_if_pc4_n   = w_pc_plus4;
          w_pc_n       = w_pc_plus4;
        end else if (w_ack) begin
          w_skid_load = 1'b1;
          w_pc_n      = w_pc_plus4;
          w_state_n   = IF_HOLD;
        end else if (!stall) begin
          w_bubble = 1'b1;
        end
      end
      IF_HOLD: begin
        if (redirect) begin
          w_pc_n       = w_redir_pc;
          w_bubble     = 1'b1;
          w_skid_clear = 1'b1;
          w_state_n    = IF_FETCH;
        end else if (!stall) begin
          w_if_valid_n  = w_skid_valid;
          w_if_inst_n   = w_skid_inst;
          w_if_pc4_n    = w_skid_pc4;
          w_skid_unload = 1'b1;
          w_state_n     = IF_FETCH;
        end
      end
      IF_DROP: begin
        if (redirect) begin
          w_pc_n       = w_redir_pc;
          w_bubble     = 1'b1;
          w_skid_clear = 1'b1;
        end else if (!stall) begin
          w_bubble = 1'b1;
        end
        if (w_ack) begin
          w_state_n = IF_FETCH;
        end
      end
      default: begin
        w_state_n = IF_FETCH;
      end
    endcase
    if (w_bubble) begin
      w_if_valid_n = 1'b0;
      w_if_inst_n  = LEN_INST'(NOP_INST);
    end
    // The stale address stays on the bus until its ack drains.
    w_addr_n = (w_state_n == IF_DROP) ? r_addr : w_pc_n;
    w_req_n  = (w_state_n != IF_HOLD);
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = r_if_valid;
  assign if_inst   = r_if_inst;
  assign if_pc4    = r_if_pc4;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench for inst_fetch: memory returns rdata = address, IF/ID stream checked in order.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;

  logic        h_req;
  logic [31:0] h_addr;
  logic [31:0] h_rdata;
  logic        h_valid;
  logic [31:0] h_inst;
  logic [31:0] h_pc4;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic        stall_q;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr;
  assign h_rdata    = h_addr;

  inst_fetch #(
    .LEN_INST (32),
    .LEN_ADDR (32),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc4      (if_pc4)
  );

  inst_fetch #(
    .LEN_INST (32),
    .LEN_ADDR (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_hi (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (h_req),
    .imem_addr   (h_addr),
    .imem_ack    (1'b1),
    .imem_rdata  (h_rdata),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .if_valid    (h_valid),
    .if_inst     (h_inst),
    .if_pc4      (h_pc4)
  );

  always @(posedge clk) stall_q <= stall;

  // A new IF/ID entry appears whenever it is valid and was not held by stall.
  always @(negedge clk) begin
    logic [31:0] exp_a;
    logic [31:0] exp_p;
    if (rst_n === 1'b1 && if_valid === 1'b1 && stall_q === 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got inst=%h pc4=%h exp=none", if_inst, if_pc4);
      end else begin
        exp_a = exp_q.pop_front();
        exp_p = exp_a + 32'd4;
        if (if_inst !== exp_a || if_pc4 !== exp_p) begin
          bad++;
          $display("FAIL sb_inst got inst=%h pc4=%h exp inst=%h pc4=%h", if_inst, if_pc4, exp_a, exp_p);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc4 !== 32'h0) begin
      bad++; $display("FAIL rst_ifid got v=%b i=%h p=%h exp 0/0/0", if_valid, if_inst, if_pc4); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (h_req !== 1'b0 || h_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL rst_hi got req=%b addr=%h exp 0/fffffffc", h_req, h_addr); end
    #3 rst_n = 1'b1;
    cyc();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      bad++; $display("FAIL rel_first got req=%b addr=%h v=%b exp 1/0/0", imem_req, imem_addr, if_valid); end
    total++; if (h_req !== 1'b1 || h_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL rel_hi got req=%b addr=%h exp 1/fffffffc", h_req, h_addr); end
    cyc();
    total++; if (h_valid !== 1'b1 || h_inst !== 32'hFFFF_FFFC || h_pc4 !== 32'h0 || h_addr !== 32'h0) begin
      bad++; $display("FAIL hi_wrap got v=%b i=%h p=%h a=%h exp 1/fffffffc/0/0", h_valid, h_inst, h_pc4, h_addr); end
  endtask

  task automatic test_stream();
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (imem_addr !== 32'(4 * (i + 1)) || if_valid !== 1'b1 || if_pc4 !== 32'(4 * (i + 1))) begin
        bad++; $display("FAIL stream_%0d got a=%h v=%b p=%h exp a=p=%h v=1", i, imem_addr, if_valid, if_pc4, 32'(4 * (i + 1))); end
    end
  endtask

  task automatic test_stall_hold();
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (imem_req !== 1'b0 || if_inst !== 32'h0C || if_valid !== 1'b1) begin
        bad++; $display("FAIL hold_%0d got req=%b i=%h v=%b exp 0/0c/1", i, imem_req, if_inst, if_valid); end
    end
    stall = 1'b0;
    cyc();
    total++; if (if_inst !== 32'h10 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      bad++; $display("FAIL unhold got i=%h req=%b a=%h exp 10/1/14", if_inst, imem_req, imem_addr); end
    cyc();
    total++; if (if_inst !== 32'h14 || imem_addr !== 32'h18) begin
      bad++; $display("FAIL after_hold got i=%h a=%h exp 14/18", if_inst, imem_addr); end
  endtask

  task automatic test_redirect_ack();
    exp_q.push_back(32'h18);
    exp_q.push_back(32'h1C);
    cyc();
    cyc();
    total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL pre_redir got=%h exp=20", imem_addr); end
    redirect = 1'b1;
    redirect_pc = 32'h40;
    exp_q.push_back(32'h40);
    cyc();
    redirect = 1'b0;
    total++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || imem_addr !== 32'h40) begin
      bad++; $display("FAIL redir_bubble got v=%b i=%h a=%h exp 0/0/40", if_valid, if_inst, imem_addr); end
    cyc();
    total++; if (if_valid !== 1'b1 || if_inst !== 32'h40 || imem_addr !== 32'h44) begin
      bad++; $display("FAIL redir_next got v=%b i=%h a=%h exp 1/40/44", if_valid, if_inst, imem_addr); end
  endtask

  task automatic test_drop();
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h80;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      total++; if (imem_addr !== 32'h44 || imem_req !== 1'b1 || if_valid !== 1'b0) begin
        bad++; $display("FAIL drop_wait_%0d got a=%h req=%b v=%b exp 44/1/0", i, imem_addr, imem_req, if_valid); end
    end
    imem_ack = 1'b1;
    cyc();
    total++; if (if_valid !== 1'b0 || imem_addr !== 32'h80) begin
      bad++; $display("FAIL drop_ack got v=%b a=%h exp 0/80", if_valid, imem_addr); end
    exp_q.push_back(32'h80);
    cyc();
    total++; if (if_inst !== 32'h80 || imem_addr !== 32'h84) begin
      bad++; $display("FAIL drop_next got i=%h a=%h exp 80/84", if_inst, imem_addr); end
  endtask

  task automatic test_hold_redirect();
    stall = 1'b1;
    cyc();
    total++; if (imem_req !== 1'b0 || if_inst !== 32'h80) begin
      bad++; $display("FAIL hr_hold got req=%b i=%h exp 0/80", imem_req, if_inst); end
    redirect = 1'b1;
    redirect_pc = 32'h103;
    cyc();
    redirect = 1'b0;
    stall = 1'b0;
    total++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc4 !== 32'h84 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin
      bad++; $display("FAIL hr_flush got v=%b i=%h p=%h a=%h req=%b exp 0/0/84/100/1", if_valid, if_inst, if_pc4, imem_addr, imem_req); end
    exp_q.push_back(32'h100);
    cyc();
    total++; if (if_inst !== 32'h100 || imem_addr !== 32'h104) begin
      bad++; $display("FAIL hr_next got i=%h a=%h exp 100/104", if_inst, imem_addr); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    total++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_redir got a=%h v=%b exp fffffffc/0", imem_addr, if_valid); end
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    cyc();
    total++; if (if_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_pc4 got p=%h a=%h exp 0/0", if_pc4, imem_addr); end
    cyc();
    total++; if (if_pc4 !== 32'h4 || imem_addr !== 32'h4) begin
      bad++; $display("FAIL wrap_next got p=%h a=%h exp 4/4", if_pc4, imem_addr); end
  endtask

  task automatic test_drop_twice();
    imem_ack = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    total++; if (imem_addr !== 32'h4 || if_valid !== 1'b0) begin
      bad++; $display("FAIL drop2_wait got a=%h v=%b exp 4/0", imem_addr, if_valid); end
    imem_ack = 1'b1;
    cyc();
    total++; if (imem_addr !== 32'h300 || if_valid !== 1'b0) begin
      bad++; $display("FAIL drop2_ack got a=%h v=%b exp 300/0", imem_addr, if_valid); end
    exp_q.push_back(32'h300);
    cyc();
    total++; if (if_inst !== 32'h300 || imem_addr !== 32'h304) begin
      bad++; $display("FAIL drop2_next got i=%h a=%h exp 300/304", if_inst, imem_addr); end
  endtask

  task automatic test_stall_wait();
    imem_ack = 1'b0;
    stall = 1'b1;
    cyc();
    total++; if (if_valid !== 1'b1 || if_inst !== 32'h300 || imem_addr !== 32'h304) begin
      bad++; $display("FAIL sw_hold got v=%b i=%h a=%h exp 1/300/304", if_valid, if_inst, imem_addr); end
    stall = 1'b0;
    cyc();
    total++; if (if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc4 !== 32'h304 || imem_req !== 1'b1 || imem_addr !== 32'h304) begin
      bad++; $display("FAIL sw_bubble got v=%b i=%h p=%h req=%b a=%h exp 0/0/304/1/304", if_valid, if_inst, if_pc4, imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    #2 rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_inst !== 32'h0 || if_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL rmid_async got req=%b v=%b i=%h p=%h a=%h exp all 0", imem_req, if_valid, if_inst, if_pc4, imem_addr); end
    imem_ack = 1'b1;
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_rel got req=%b a=%h v=%b exp 1/0/0", imem_req, imem_addr, if_valid); end
    exp_q.push_back(32'h0);
    cyc();
    total++; if (if_valid !== 1'b1 || if_pc4 !== 32'h4 || imem_addr !== 32'h4) begin
      bad++; $display("FAIL rmid_refetch got v=%b p=%h a=%h exp 1/4/4", if_valid, if_pc4, imem_addr); end
    imem_ack = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_ack();
    test_drop();
    test_hold_redirect();
    test_wrap();
    test_drop_twice();
    test_stall_wait();
    test_reset_mid();
    repeat (3) cyc();
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter LEN_INST, default 32, instruction width (shared `LEN_INST`).
REQ-002 Parameter LEN_ADDR, default 32, byte-address width.
REQ-003 Parameter RESET_PC, default 0, first fetch address.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  LEN_ADDR  fetch byte address.
REQ-008 imem_ack  input  1  memory returns imem_rdata this cycle; same-cycle or later.
REQ-009 imem_rdata  input  LEN_INST  fetched instruction, valid only with imem_ack.
REQ-010 stall  input  1  hazard unit holds the IF/ID register.
REQ-011 redirect  input  1  branch/jump taken; flush and refetch.
REQ-012 redirect_pc  input  LEN_ADDR  redirect target.
REQ-013 if_valid  output  1  IF/ID holds a real instruction.
REQ-014 if_inst  output  LEN_INST  IF/ID instruction, NOP (all zero) when invalid.
REQ-015 if_pc4  output  LEN_ADDR  IF/ID address of instruction + 4.

Function
REQ-016 FSM states: FETCH (request outstanding), HOLD (instruction parked in skid buffer, stalled), DROP (discarding a stale outstanding request).
REQ-017 In FETCH and DROP, imem_req = 1; in HOLD, imem_req = 0.
REQ-018 imem_addr = pc and stays stable from request until imem_ack; pc changes only on ack or in HOLD/DROP exit.
REQ-019 FETCH, ack, no stall, no redirect: if_inst <= imem_rdata, if_valid <= 1, if_pc4 <= pc+4, pc <= pc+4, stay FETCH; sustained rate one instruction per cycle with same-cycle ack.
REQ-020 FETCH, ack, stall: IF/ID unchanged, rdata and pc+4 into skid buffer, pc <= pc+4, go HOLD.
REQ-021 FETCH, no ack, no stall: IF/ID loads bubble (if_valid 0, if_inst 0, if_pc4 unchanged).
REQ-022 Any state, stall without redirect and no ack: IF/ID unchanged.
REQ-023 HOLD, stall deasserted: skid buffer into IF/ID, skid emptied, go FETCH next cycle.
REQ-024 Redirect has priority over stall and ack: IF/ID loads bubble, skid emptied, pc <= {redirect_pc[LEN_ADDR-1:2], 2'b00}.
REQ-025 Redirect in FETCH with ack, or in HOLD: go FETCH; rdata discarded.
REQ-026 Redirect in FETCH without ack: go DROP; imem_addr keeps the old address until ack.
REQ-027 DROP, ack: discard rdata, go FETCH at the redirected pc; a second redirect in DROP updates pc only.
REQ-028 IF/ID during DROP: bubble unless stall is high, in which case it holds.
REQ-029 pc+4 wraps modulo 2^LEN_ADDR (0xFFFFFFFC -> 0x00000000).
REQ-030 imem_ack outside a request is ignored.

Reset
REQ-031 On rst_n low, asynchronously: state FETCH, pc = RESET_PC, skid empty, if_valid 0, if_inst 0, if_pc4 0.
REQ-032 imem_req is 0 while rst_n is low and 1 from the first clock edge after release.
REQ-033 Reset mid-request abandons the request; a late ack after release is not issued against the old address.

Structure
REQ-034 `LEN_INST`, `LEN_ADDR` and the NOP encoding live in defs.v beside the opcode/ALU constants; the FSM state encoding lives there as `IF_FETCH`, `IF_HOLD`, `IF_DROP`.
REQ-035 The skid buffer (valid, inst, pc4; load/unload/clear) is one sub-module, inst_skid_buf; everything else is flat.

Verification
REQ-036 Reset release, ack tied high, rdata = addr: imem_addr 0,4,8,...; if_valid high from cycle 2; if_pc4 = 4,8,12.
REQ-037 Stall for 3 cycles during ack at addr 0x10: IF/ID holds 0x0C's instruction; HOLD; imem_req 0; after release 0x10 appears, then 0x14 with no loss or duplication.
REQ-038 Redirect to 0x40 with same-cycle ack at 0x20: 0x20 discarded, one bubble, next imem_addr 0x40.
REQ-039 Ack delayed 3 cycles, redirect to 0x80 in first wait cycle: imem_addr held at old value until ack (DROP), then 0x80; no stale instruction reaches IF/ID.
REQ-040 Redirect to 0x103 with stall high in HOLD: skid flushed, bubble, next fetch 0x100.
REQ-041 RESET_PC = 0xFFFFFFFC: first if_pc4 = 0, next imem_addr 0; rst_n pulsed mid-wait: outputs zero immediately, refetch from RESET_PC.
